mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data bus width.
REQ-002 Parameter ADDR_WIDTH, default 32, SHALL set the byte-address bus width.
REQ-003 Parameter STARVE_LIMIT, default 4, SHALL set the maximum consecutive data-port grants while fetch waits.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock, same clock as the RAM.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 i_req  in  1  fetch read request; i_addr  in  ADDR_WIDTH  fetch byte address.
REQ-008 i_gnt  out  1  fetch request accepted this cycle; i_rvalid  out  1  fetch read data valid; i_rdata  out  DATA_WIDTH  fetch read data.
REQ-009 d_req  in  1  data request; d_we  in  1  1=store, 0=load; d_addr  in  ADDR_WIDTH; d_wdata  in  DATA_WIDTH.
REQ-010 d_gnt  out  1  data request accepted; d_rvalid  out  1  load data valid; d_rdata  out  DATA_WIDTH.
REQ-011 ram_addr  out  ADDR_WIDTH; ram_data  out  DATA_WIDTH; ram_MemWrite  out  1; ram_MemRead  out  1; ram_q  in  DATA_WIDTH; all connect to the single-port RAM.

Function
REQ-012 At most one of i_gnt/d_gnt SHALL be high per cycle; grants SHALL be combinational from the current-cycle requests and arbitration state.
REQ-013 Priority: d_req wins over i_req unless the starvation counter equals STARVE_LIMIT, in which case i_req wins.
REQ-014 Starvation counter: increments on each cycle with d_gnt=1 and i_req=1, saturating at STARVE_LIMIT; clears on i_gnt=1 or when i_req=0.
REQ-015 Granted fetch: ram_addr=i_addr, ram_MemRead=1, ram_MemWrite=0.
REQ-016 Granted load: ram_addr=d_addr, ram_MemRead=1, ram_MemWrite=0; granted store: ram_addr=d_addr, ram_data=d_wdata, ram_MemWrite=1, ram_MemRead=0.
REQ-017 No grant: ram_MemWrite=0, ram_MemRead=0, ram_addr holds the last granted address.
REQ-018 Read latency: a read granted in cycle N SHALL raise the matching rvalid for exactly cycle N+1, with rdata=ram_q.
REQ-019 Stores SHALL complete in the grant cycle; a store SHALL never raise d_rvalid.
REQ-020 A registered response tag (NONE/FETCH/LOAD) SHALL route ram_q; back-to-back grants every cycle SHALL be supported with no bubble.
REQ-021 i_rdata and d_rdata SHALL both carry ram_q; only the rvalid qualifies.
REQ-022 A store in cycle N followed by a read of the same word in cycle N+1 SHALL return the stored data in cycle N+2.
REQ-023 Requesters SHALL hold req, addr, we and wdata stable until gnt; the arbiter SHALL not check this.
REQ-024 Deasserting req before gnt SHALL withdraw the request with no RAM access.

Reset
REQ-025 While rst_n=0: i_gnt, d_gnt, i_rvalid, d_rvalid, ram_MemWrite and ram_MemRead SHALL be 0; ram_addr=0; response tag=NONE; starvation counter=0.
REQ-026 Reset asserted mid-read SHALL discard the pending response; no rvalid SHALL follow deassertion.
REQ-027 The first grant SHALL be possible in the first rising edge after rst_n deasserts.

Structure
REQ-028 A shared package SHALL hold the response-tag enum (NONE, FETCH, LOAD) and the default STARVE_LIMIT constant.
REQ-029 The design SHALL be a single module with no sub-modules; the RAM is instantiated beside it at the top level.

Verification
REQ-030 Fetch-only: i_req=1, i_addr=0x00, 0x04, 0x08 in consecutive cycles -> i_gnt=1 each cycle; i_rvalid=1 in cycles 2-4 with words 0, 1 and 2.
REQ-031 Store then load: store 0xDEADBEEF at 0x10 in cycle N, load 0x10 in cycle N+1 -> d_rvalid=1 and d_rdata=0xDEADBEEF in cycle N+2; d_rvalid=0 in cycle N+1.
REQ-032 Contention: i_req=1 and d_req=1 held for 6 cycles with STARVE_LIMIT=4 -> d_gnt in cycles 1-4, i_gnt in cycle 5, d_gnt in cycle 6.
REQ-033 Alternating stream: load 0x20, fetch 0x24, load 0x28 in consecutive cycles -> d_rvalid, i_rvalid and d_rvalid in the next three cycles, with the correct words and never both rvalids high together.
REQ-034 Reset mid-read: grant a fetch of 0x30, assert rst_n=0 before the next edge -> i_rvalid stays 0 and all grant and RAM strobes stay 0 until after deassertion.
REQ-035 Withdrawal: i_req=1 for one cycle while d_req wins, then i_req=0 -> no i_gnt, no i_rvalid, and the starvation counter returns to 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the fetch/data single-port RAM arbiter.
package mem_arbiter_pkg;

  // Which requester owns the read data returned by the RAM in the next cycle
  typedef enum logic [1:0] {
    RSP_NONE  = 2'd0,
    RSP_FETCH = 2'd1,
    RSP_LOAD  = 2'd2
  } rsp_tag_e;

  localparam int STARVE_LIMIT_DEFAULT = 4;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one synchronous single-port RAM.
// Data wins by default; fetch is forced through after STARVE_LIMIT consecutive data wins.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_MemWrite,
  output logic                  ram_MemRead,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  rsp_tag_e               r_tag;
  rsp_tag_e               w_tag_next;
  logic [CNT_W-1:0]       r_starve;
  logic [CNT_W-1:0]       w_starve_next;
  logic [ADDR_WIDTH-1:0]  r_last_addr;
  logic                   w_fetch_pri;
  logic                   w_store;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag       <= RSP_NONE;
      r_starve    <= '0;
      r_last_addr <= '0;
    end else begin
      r_tag    <= w_tag_next;
      r_starve <= w_starve_next;
      if (i_gnt || d_gnt) begin
        r_last_addr <= ram_addr;
      end
    end
  end

  always_comb begin
    w_fetch_pri   = (r_starve == CNT_MAX);
    // Grants are gated by rst_n so nothing reaches the RAM while reset is held
    i_gnt         = rst_n & i_req & (~d_req | w_fetch_pri);
    d_gnt         = rst_n & d_req & ~i_gnt;
    w_store       = d_gnt & d_we;

    ram_MemRead   = i_gnt | (d_gnt & ~d_we);
    ram_MemWrite  = w_store;
    ram_data      = w_store ? d_wdata : '0;
    ram_addr      = r_last_addr;
    if (i_gnt) begin
      ram_addr = i_addr;
    end else if (d_gnt) begin
      ram_addr = d_addr;
    end

    w_tag_next = RSP_NONE;
    if (i_gnt) begin
      w_tag_next = RSP_FETCH;
    end else if (d_gnt && !d_we) begin
      w_tag_next = RSP_LOAD;
    end

    w_starve_next = r_starve;
    if (!i_req || i_gnt) begin
      w_starve_next = '0;
    end else if (d_gnt && (r_starve != CNT_MAX)) begin
      w_starve_next = r_starve + CNT_W'(1);
    end
  end

  // Both read ports see the RAM output; only the tag-derived rvalid qualifies it
  assign i_rvalid = (r_tag == RSP_FETCH);
  assign d_rvalid = (r_tag == RSP_LOAD);
  assign i_rdata  = ram_q;
  assign d_rdata  = ram_q;

endmodule : mem_arbiter
